// File: rtl/memory_cycle.sv
// M stage of the RV32I pipeline: data memory with byte/half/word stores and
// extending loads, misalignment detection, and the M/W pipeline register.
module memory_cycle #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] InstrM,
  input  logic [31:0] AuLu_ResultM,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] AuLu_ResultW,
  output logic [31:0] InstrW,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic        MisalignW
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned LANES = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [XLEN-1:0] mem [DEPTH];

  logic [2:0]        funct3_c;
  logic [ADDR_W-1:0] word_idx_c;
  logic [1:0]        lane_c;
  logic              is_load_c;
  logic              misalign_c;
  logic              load_misalign_c;
  logic              store_en_c;
  logic [LANES-1:0]  byte_en_c;
  logic [XLEN-1:0]   wdata_lane_c;
  logic [XLEN-1:0]   rdata_word_c;
  logic [7:0]        rbyte_c;
  logic [15:0]       rhalf_c;

  logic [XLEN-1:0] alu_result_q, read_data_q, read_data_d, pc_plus4_q, aulu_result_q, instr_q;
  logic [4:0]      rd_q;
  logic            reg_write_q, reg_write_d, misalign_q;
  logic [1:0]      result_src_q;

  assign funct3_c   = InstrM[14:12];
  assign word_idx_c = ALUResultM[ADDR_W+1:2];
  assign lane_c     = ALUResultM[1:0];
  assign is_load_c  = (ResultSrcM == 2'b01);

  // Misalignment only matters for memory accesses; byte accesses never misalign.
  always_comb begin
    misalign_c = 1'b0;
    if (MemWriteM || is_load_c) begin
      unique case (funct3_c[1:0])
        2'b01:   misalign_c = lane_c[0];
        2'b10:   misalign_c = (lane_c != 2'b00);
        default: misalign_c = 1'b0;
      endcase
    end
  end

  assign load_misalign_c = misalign_c && is_load_c;

  // Byte enables and lane-replicated write data per store width.
  always_comb begin
    byte_en_c    = '0;
    wdata_lane_c = WriteDataM;
    unique case (funct3_c)
      F3_B: begin
        byte_en_c    = LANES'(4'b0001 << lane_c);
        wdata_lane_c = {4{WriteDataM[7:0]}};
      end
      F3_H: begin
        byte_en_c    = lane_c[1] ? 4'b1100 : 4'b0011;
        wdata_lane_c = {2{WriteDataM[15:0]}};
      end
      F3_W:    byte_en_c = 4'b1111;
      default: byte_en_c = '0;
    endcase
  end

  assign store_en_c = MemWriteM && !rst && !misalign_c;

  // Data RAM: contents survive reset.
  always_ff @(posedge clk) begin
    if (store_en_c) begin
      for (int b = 0; b < int'(LANES); b++) begin
        if (byte_en_c[b]) mem[word_idx_c][8*b +: 8] <= wdata_lane_c[8*b +: 8];
      end
    end
  end

  assign rdata_word_c = mem[word_idx_c];
  assign rbyte_c      = rdata_word_c[{lane_c, 3'b000} +: 8];
  assign rhalf_c      = lane_c[1] ? rdata_word_c[31:16] : rdata_word_c[15:0];

  // Load lane selection and extension.
  always_comb begin
    read_data_d = '0;
    unique case (funct3_c)
      F3_B:    read_data_d = {{24{rbyte_c[7]}}, rbyte_c};
      F3_BU:   read_data_d = {24'h0, rbyte_c};
      F3_H:    read_data_d = {{16{rhalf_c[15]}}, rhalf_c};
      F3_HU:   read_data_d = {16'h0, rhalf_c};
      F3_W:    read_data_d = rdata_word_c;
      default: read_data_d = '0;
    endcase
    if (load_misalign_c) read_data_d = '0;
  end

  assign reg_write_d = RegWriteM && !load_misalign_c;

  // M/W pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_q  <= '0;
      read_data_q   <= '0;
      pc_plus4_q    <= '0;
      aulu_result_q <= '0;
      instr_q       <= '0;
      rd_q          <= '0;
      reg_write_q   <= 1'b0;
      result_src_q  <= '0;
      misalign_q    <= 1'b0;
    end else begin
      alu_result_q  <= ALUResultM;
      read_data_q   <= read_data_d;
      pc_plus4_q    <= PCPlus4M;
      aulu_result_q <= AuLu_ResultM;
      instr_q       <= InstrM;
      rd_q          <= RdM;
      reg_write_q   <= reg_write_d;
      result_src_q  <= ResultSrcM;
      misalign_q    <= misalign_c;
    end
  end

  assign ALUResultW   = alu_result_q;
  assign ReadDataW    = read_data_q;
  assign PCPlus4W     = pc_plus4_q;
  assign AuLu_ResultW = aulu_result_q;
  assign InstrW       = instr_q;
  assign RdW          = rd_q;
  assign RegWriteW    = reg_write_q;
  assign ResultSrcW   = result_src_q;
  assign MisalignW    = misalign_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Scoreboard bench for memory_cycle: directed M-stage vectors push expected
// W-stage values; a monitor pops one entry per cycle and compares.
module tb_memory_cycle;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, InstrM, AuLu_ResultM;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W, AuLu_ResultW, InstrW;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic        MisalignW;

  memory_cycle #(.DEPTH(DEPTH), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .InstrM(InstrM), .AuLu_ResultM(AuLu_ResultM), .RdM(RdM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .AuLu_ResultW(AuLu_ResultW), .InstrW(InstrW), .RdW(RdW),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .MisalignW(MisalignW)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          chk_zero;
    bit          chk_rd;
    logic [31:0] rd_exp;
    bit          chk_misal;
    logic        misal;
    bit          chk_regw;
    logic        regw;
    bit          chk_pass;
    logic [4:0]  rdw;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: W outputs are valid one edge after each issued M-stage cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.chk_zero) begin
          check({e.name, ".ALUResultW"},   ALUResultW,   32'h0);
          check({e.name, ".ReadDataW"},    ReadDataW,    32'h0);
          check({e.name, ".PCPlus4W"},     PCPlus4W,     32'h0);
          check({e.name, ".AuLu_ResultW"}, AuLu_ResultW, 32'h0);
          check({e.name, ".InstrW"},       InstrW,       32'h0);
          check({e.name, ".RdW"},          32'(RdW),       32'h0);
          check({e.name, ".RegWriteW"},    32'(RegWriteW), 32'h0);
          check({e.name, ".ResultSrcW"},   32'(ResultSrcW), 32'h0);
          check({e.name, ".MisalignW"},    32'(MisalignW), 32'h0);
        end
        if (e.chk_rd)    check({e.name, ".ReadDataW"}, ReadDataW, e.rd_exp);
        if (e.chk_misal) check({e.name, ".MisalignW"}, 32'(MisalignW), 32'(e.misal));
        if (e.chk_regw)  check({e.name, ".RegWriteW"}, 32'(RegWriteW), 32'(e.regw));
        if (e.chk_pass) begin
          check({e.name, ".RdW"},      32'(RdW), 32'(e.rdw));
          check({e.name, ".PCPlus4W"}, PCPlus4W, e.pc);
          check({e.name, ".InstrW"},   InstrW,   e.instr);
        end
      end
    end
  end

  function automatic exp_t blank(input string name);
    exp_t e;
    e.name = name; e.chk_zero = 0; e.chk_rd = 0; e.rd_exp = '0;
    e.chk_misal = 0; e.misal = 0; e.chk_regw = 0; e.regw = 0;
    e.chk_pass = 0; e.rdw = '0; e.pc = '0; e.instr = '0;
    return e;
  endfunction

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd);
    return {17'h0, f3, rd, 7'h03};
  endfunction

  task automatic drive(input logic r, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic mw, input logic [1:0] rs,
                       input logic rw, input logic [4:0] rd, input logic [31:0] pc,
                       input exp_t e);
    rst = r; InstrM = mk_instr(f3, rd); ALUResultM = addr; WriteDataM = wd;
    MemWriteM = mw; ResultSrcM = rs; RegWriteM = rw; RdM = rd;
    PCPlus4M = pc; AuLu_ResultM = 32'hA5A5_0000 ^ pc;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic misal);
    exp_t e = blank(name);
    e.chk_misal = 1; e.misal = misal;
    drive(1'b0, f3, addr, wd, 1'b1, 2'b00, 1'b0, 5'd0, 32'h200, e);
  endtask

  task automatic load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] exp_data, input logic misal);
    exp_t e = blank(name);
    e.chk_rd = 1; e.rd_exp = exp_data;
    e.chk_misal = 1; e.misal = misal;
    e.chk_regw = 1; e.regw = !misal;
    drive(1'b0, f3, addr, 32'h0, 1'b0, 2'b01, 1'b1, 5'd5, 32'h300, e);
  endtask

  initial begin
    exp_t e;
    int   wait_cyc;
    rst = 1'b1; ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0; InstrM = '0;
    AuLu_ResultM = '0; RdM = '0; RegWriteM = 0; MemWriteM = 0; ResultSrcM = '0;

    e = blank("reset0"); e.chk_zero = 1;
    drive(1'b1, 3'b000, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, e);

    // Reset with a store presented: outputs cleared, store not committed.
    store("pre_sw0", 3'b010, 32'h10, 32'h0, 1'b0);
    e = blank("reset_sw"); e.chk_zero = 1;
    drive(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, 2'b01, 1'b1, 5'd9, 32'h44, e);
    load("lw_after_rst", 3'b010, 32'h10, 32'h0, 1'b0);

    store("sw_20", 3'b010, 32'h20, 32'h11223344, 1'b0);
    load("lw_20", 3'b010, 32'h20, 32'h11223344, 1'b0);

    store("sb_21", 3'b000, 32'h21, 32'h000000AA, 1'b0);
    load("lw_20_sb", 3'b010, 32'h20, 32'h1122AA44, 1'b0);
    load("lb_21", 3'b000, 32'h21, 32'hFFFFFFAA, 1'b0);
    load("lbu_21", 3'b100, 32'h21, 32'h000000AA, 1'b0);

    store("sh_22", 3'b001, 32'h22, 32'h00008001, 1'b0);
    load("lh_22", 3'b001, 32'h22, 32'hFFFF8001, 1'b0);
    load("lhu_22", 3'b101, 32'h22, 32'h00008001, 1'b0);
    load("lw_20_sh", 3'b010, 32'h20, 32'h8001AA44, 1'b0);
    load("lb_23", 3'b000, 32'h23, 32'hFFFFFF80, 1'b0);
    load("lbu_22", 3'b100, 32'h22, 32'h00000001, 1'b0);

    // Misaligned and unsupported-funct3 accesses.
    load("lw_22_mis", 3'b010, 32'h22, 32'h0, 1'b1);
    load("lh_21_mis", 3'b001, 32'h21, 32'h0, 1'b1);
    store("sw_21_mis", 3'b010, 32'h21, 32'h12345678, 1'b1);
    store("sh_23_mis", 3'b001, 32'h23, 32'h0000FFFF, 1'b1);
    store("st_f3_011", 3'b011, 32'h20, 32'hFFFFFFFF, 1'b0);
    load("lw_20_keep", 3'b010, 32'h20, 32'h8001AA44, 1'b0);
    load("ld_f3_011", 3'b011, 32'h20, 32'h0, 1'b0);

    // Aliasing modulo 4*DEPTH bytes.
    store("sw_alias", 3'b010, 32'(4 * DEPTH) + 32'h30, 32'h00000055, 1'b0);
    load("lw_30", 3'b010, 32'h30, 32'h00000055, 1'b0);
    load("lw_hi_alias", 3'b010, 32'hFFFFF030, 32'h00000055, 1'b0);

    // Plain ALU op passthrough.
    e = blank("alu_pass"); e.chk_pass = 1; e.rdw = 5'd7; e.pc = 32'h104;
    e.instr = mk_instr(3'b000, 5'd7); e.chk_regw = 1; e.regw = 1'b1;
    e.chk_misal = 1; e.misal = 1'b0;
    drive(1'b0, 3'b000, 32'h21, 32'h0, 1'b0, 2'b00, 1'b1, 5'd7, 32'h104, e);

    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 2'b00;
    wait_cyc = 0;
    while (q.size() != 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached expected completion");
    $fatal(1, "watchdog");
  end

endmodule
